// File: rtl/baud_tick_gen_if.sv
// Bus between the baud tick generator and its user (UART TX/RX pair).
//   en        accumulate enable
//   sync      single-cycle phase restart (RX start-edge alignment)
//   inc_wr    load strobe for inc_data
//   inc_data  new phase increment
//   inc_q     currently active increment (readback)
//   OsTick    one-cycle oversampled tick
//   BaudTick  one-cycle 1x tick, every Oversample OsTicks
// The user side takes the master modport, the generator the slave modport.
interface baud_tick_gen_if #(
    parameter int AccWidth = 20
);
    logic                en;
    logic                sync;
    logic                inc_wr;
    logic [AccWidth-1:0] inc_data;
    logic [AccWidth-1:0] inc_q;
    logic                OsTick;
    logic                BaudTick;

    modport master (
        output en, sync, inc_wr, inc_data,
        input  inc_q, OsTick, BaudTick
    );

    modport slave (
        input  en, sync, inc_wr, inc_data,
        output inc_q, OsTick, BaudTick
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional phase-accumulator baud tick generator.
// A W-bit accumulator adds a programmable increment every enabled cycle;
// its carry out becomes OsTick (registered, one cycle after the overflowing
// add). Every Oversample OsTicks a BaudTick is issued together with the
// OsTick. A sync pulse restarts the phase so that the next BaudTick lands
// at mid-bit, letting the receiver realign on a start edge.
// Ports:
//   clk  main clock, rising edge
//   rst  asynchronous active-high reset
//   bus  baud_tick_gen_if slave: en, sync, inc_wr, inc_data in;
//        inc_q, OsTick, BaudTick out
module baud_tick_gen #(
    parameter int unsigned ClkFrequency = 12000000,
    parameter int unsigned Baud         = 115200,
    parameter int          AccWidth     = 20,
    parameter int          Oversample   = 16,
    parameter int          SyncPhase    = Oversample / 2
) (
    input  logic           clk,
    input  logic           rst,
    baud_tick_gen_if.slave bus
);

    // Reset increment, rounded to nearest: Baud*Oversample*2^W / ClkFrequency.
    localparam logic [63:0] Num      = (64'(Baud) * 64'(Oversample)) << AccWidth;
    localparam logic [63:0] Inc0Wide = (Num + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [AccWidth-1:0] Inc0 = Inc0Wide[AccWidth-1:0];

    localparam int CntWidth = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(Oversample - 1);
    localparam logic [CntWidth-1:0] CntSync  = CntWidth'(SyncPhase);

    if (Inc0Wide == 64'd0 || Inc0Wide >= (64'd1 << AccWidth)) begin : g_bad_inc0
        $error("baud_tick_gen: reset increment out of range for AccWidth");
    end
    if (Oversample < 1) begin : g_bad_oversample
        $error("baud_tick_gen: Oversample must be >= 1");
    end
    if (SyncPhase < 0 || SyncPhase >= Oversample) begin : g_bad_sync_phase
        $error("baud_tick_gen: SyncPhase must lie in 0..Oversample-1");
    end

    logic [AccWidth-1:0] acc;
    logic [AccWidth-1:0] inc_q;
    logic [CntWidth-1:0] os_cnt;
    logic                os_tick;
    logic                baud_tick;

    // One extra bit on the sum holds the carry that becomes OsTick.
    logic [AccWidth:0]   sum;
    logic                carry;

    assign sum   = {1'b0, acc} + {1'b0, inc_q};
    assign carry = sum[AccWidth];

    // NOTE: every register here is reset, including ticks, so an in-flight
    // pulse is dropped as soon as rst rises, without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            os_cnt    <= '0;
            inc_q     <= Inc0;
            os_tick   <= 1'b0;
            baud_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments mean the add below still sees
            // the old inc_q on the edge a new value is written; the new
            // increment is first used one cycle later.
            if (bus.inc_wr) begin
                inc_q <= bus.inc_data;
            end

            if (bus.sync) begin
                // Restart the phase; any overflow from this cycle is lost.
                acc       <= '0;
                os_cnt    <= CntSync;
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
            end else if (bus.en) begin
                acc       <= sum[AccWidth-1:0];
                os_tick   <= carry;
                baud_tick <= 1'b0;
                if (carry) begin
                    if (os_cnt == CntLast) begin
                        os_cnt    <= '0;
                        baud_tick <= 1'b1;
                    end else begin
                        os_cnt <= os_cnt + 1'b1;
                    end
                end
            end else begin
                os_tick   <= 1'b0;
                baud_tick <= 1'b0;
            end
        end
    end

    assign bus.inc_q    = inc_q;
    assign bus.OsTick   = os_tick;
    assign bus.BaudTick = baud_tick;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen with default parameters
// (12 MHz, 115200 baud, W=20, Oversample=16 -> reset increment 161061).
// A table of per-cycle vectors covers increment writes, sync, enable gaps,
// zero and maximum increments; hand-written sequences cover async reset
// during a BaudTick and a long free-running rate measurement.
module tb_baud_tick_gen;

    localparam logic [19:0] INC0 = 20'd161061;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    baud_tick_gen_if #(.AccWidth(20)) bus ();

    baud_tick_gen #(
        .ClkFrequency(12000000),
        .Baud        (115200),
        .AccWidth    (20),
        .Oversample  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        en;
        logic        sync;
        logic        wr;
        logic [19:0] data;
        logic        os;
        logic        baud;
        logic [19:0] inc;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic en, input logic sync, input logic wr,
                                    input logic [19:0] data, input logic os,
                                    input logic baud, input logic [19:0] inc);
        vec_t v;
        v.en = en; v.sync = sync; v.wr = wr; v.data = data;
        v.os = os; v.baud = baud; v.inc = inc;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic en, input logic sync, input logic wr, input logic [19:0] data);
        bus.en       = en;
        bus.sync     = sync;
        bus.inc_wr   = wr;
        bus.inc_data = data;
    endtask

    initial begin
        int  os_seen, baud_seen, first_os, first_baud, last_os, last_baud;
        int  min_os_gap, max_os_gap, min_baud_gap, inc_bad;
        bit  seen;

        drive(1'b0, 1'b0, 1'b0, 20'd0);

        // ---------------- vector table ----------------
        // A: increment 2^18 -> OsTick every 4, BaudTick every 64
        add_vec(0, 0, 1, 20'h40000, 0, 0, 20'h40000);
        for (int k = 1; k <= 128; k++)
            add_vec(1, 0, 0, 20'h0, (k % 4) == 0, (k % 64) == 0, 20'h40000);
        // B: two adds to move the phase, then sync -> BaudTick after 32, then every 64
        add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        add_vec(1, 1, 0, 20'h0, 0, 0, 20'h40000);
        for (int j = 1; j <= 96; j++)
            add_vec(1, 0, 0, 20'h0, (j % 4) == 0, (j == 32) || (j == 96), 20'h40000);
        // C: enable gap of 10 mid-period -> OsTick gap of 4+10
        add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        for (int j = 0; j < 10; j++)
            add_vec(0, 0, 0, 20'h0, 0, 0, 20'h40000);
        add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        add_vec(1, 0, 0, 20'h0, 1, 0, 20'h40000);
        for (int j = 0; j < 3; j++)
            add_vec(1, 0, 0, 20'h0, 0, 0, 20'h40000);
        // D: sync + inc_wr on a cycle that would overflow -> tick discarded
        add_vec(1, 1, 1, 20'h80000, 0, 0, 20'h80000);
        for (int j = 1; j <= 32; j++)
            add_vec(1, 0, 0, 20'h0, (j % 2) == 0, j == 16, 20'h80000);
        // E: zero increment freezes acc; restoring it resumes the old phase
        add_vec(1, 0, 1, 20'h00000, 0, 0, 20'h00000);
        for (int j = 0; j < 8; j++)
            add_vec(1, 0, 0, 20'h0, 0, 0, 20'h00000);
        add_vec(1, 0, 1, 20'h80000, 0, 0, 20'h80000);
        add_vec(1, 0, 0, 20'h0, 1, 0, 20'h80000);
        // F: maximum increment -> OsTick on nearly every cycle
        add_vec(0, 1, 1, 20'hFFFFF, 0, 0, 20'hFFFFF);
        for (int k = 1; k <= 20; k++)
            add_vec(1, 0, 0, 20'h0, k >= 2, k == 9, 20'hFFFFF);
        add_vec(0, 0, 0, 20'h0, 0, 0, 20'hFFFFF);

        // ---------------- reset state ----------------
        #12;
        check("reset_os",   64'(bus.OsTick),   64'd0);
        check("reset_baud", 64'(bus.BaudTick), 64'd0);
        check("reset_inc",  64'(bus.inc_q),    64'(INC0));
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].sync, vecs[i].wr, vecs[i].data);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {43'd0, bus.OsTick, bus.BaudTick, bus.inc_q},
                  {43'd0, vecs[i].os, vecs[i].baud, vecs[i].inc});
        end

        // ---------------- async reset while BaudTick is high ----------------
        drive(1'b1, 1'b0, 1'b1, 20'h40000);
        @(posedge clk);
        @(negedge clk);
        bus.inc_wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.BaudTick === 1'b1) seen = 1'b1;
        end
        check("baud_before_rst", 64'(seen), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_baud", 64'(bus.BaudTick), 64'd0);
        check("rst_async_os",   64'(bus.OsTick),   64'd0);
        check("rst_async_acc",  64'(dut.acc),      64'd0);
        check("rst_async_cnt",  64'(dut.os_cnt),   64'd0);
        check("rst_async_inc",  64'(bus.inc_q),    64'(INC0));
        drive(1'b0, 1'b0, 1'b0, 20'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- long run at the reset increment ----------------
        // 65536 adds: floor(65536*161061/2^20) = 10066 OsTicks, 629 BaudTicks;
        // first OsTick after add 7, first BaudTick after add 105.
        os_seen = 0; baud_seen = 0; first_os = -1; first_baud = -1;
        last_os = -1; last_baud = -1; inc_bad = 0;
        min_os_gap = 1 << 30; max_os_gap = 0; min_baud_gap = 1 << 30;
        bus.en = 1'b1;
        for (int c = 1; c <= 65536; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.inc_q !== INC0) inc_bad++;
            if (bus.BaudTick === 1'b1 && bus.OsTick !== 1'b1) inc_bad++;
            if (bus.OsTick === 1'b1) begin
                os_seen++;
                if (first_os < 0) first_os = c;
                if (last_os >= 0) begin
                    if (c - last_os < min_os_gap) min_os_gap = c - last_os;
                    if (c - last_os > max_os_gap) max_os_gap = c - last_os;
                end
                last_os = c;
            end
            if (bus.BaudTick === 1'b1) begin
                baud_seen++;
                if (first_baud < 0) first_baud = c;
                if (last_baud >= 0 && c - last_baud < min_baud_gap) min_baud_gap = c - last_baud;
                last_baud = c;
            end
        end
        bus.en = 1'b0;
        check("run_os_count",      64'(os_seen),    64'd10066);
        check("run_baud_count",    64'(baud_seen),  64'd629);
        check("run_first_os",      64'(first_os),   64'd7);
        check("run_first_baud",    64'(first_baud), 64'd105);
        check("run_min_os_gap",    64'(min_os_gap), 64'd6);
        check("run_max_os_gap",    64'(max_os_gap), 64'd7);
        check("run_baud_gap_ge96", 64'(min_baud_gap >= 96), 64'd1);
        check("run_inc_and_coinc", 64'(inc_bad),    64'd0);
        @(posedge clk);
        @(negedge clk);
        check("run_stop_os", 64'(bus.OsTick), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised successor to the fixed-rate baud generator: a fractional phase-accumulator tick generator with a run-time programmable increment. It also produces an oversampled tick (OsTick) for the UART receiver and a divided 1x tick (BaudTick) for the transmitter. A phase-restart input lets the receiver realign the bit grid on a detected start edge. It sits between the clock domain root and the com/ UART TX/RX blocks; one instance serves one TX/RX pair.

Parameters:
ClkFrequency, 12000000, main clock frequency in Hz; used only to compute the reset increment.
Baud, 115200, reset baud rate in bit/s.
AccWidth, 20, fractional accumulator width W; sets rate resolution (ClkFrequency / 2^W Hz per LSB).
Oversample, 16, number of OsTick pulses per BaudTick; must be >= 1.
SyncPhase, Oversample/2, oversample-counter value loaded on sync, placing the BaudTick at mid-bit.

Ports:
clk  input  1  FPGA main clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  accumulate enable; when low, the accumulator and counter hold.
sync  input  1  single-cycle phase restart (RX start-edge alignment).
inc_wr  input  1  load strobe for inc_data.
inc_data  input  AccWidth  new increment value.
inc_q  output  AccWidth  currently active increment (readback).
OsTick  output  1  one-cycle pulse at Baud*Oversample average rate.
BaudTick  output  1  one-cycle pulse every Oversample OsTicks.

Behaviour:
- Reset increment INC0 = round(Baud*Oversample*2^W / ClkFrequency), computed at elaboration. Defaults give INC0 = 161061.
- Elaboration error if INC0 = 0 or INC0 >= 2^W.
- State: acc[W-1:0], os_cnt[max(1,clog2(Oversample))-1:0], inc_q[W-1:0]. All registered.
- While rst is high, asynchronously: acc=0, os_cnt=0, inc_q=INC0, OsTick=0, BaudTick=0. Reset mid-operation drops any pending tick.
- Priority each edge: sync > en. inc_wr is independent of both.
- inc_wr=1: inc_q <= inc_data at that edge. The new value is first used in the following cycle's addition. acc is not cleared, so the phase stays continuous.
- sync=1: acc <= 0, os_cnt <= SyncPhase, OsTick <= 0, BaudTick <= 0. This applies regardless of en, and an overflow in that same cycle is discarded.
- en=1, sync=0: {c, acc} <= acc + inc_q as a (W+1)-bit sum. OsTick <= c.
- os_cnt advances only on carry c: if c and os_cnt == Oversample-1, then os_cnt <= 0 and BaudTick <= 1. Otherwise, if c, os_cnt <= os_cnt+1. BaudTick <= 0 in all other cases.
- BaudTick always coincides with an OsTick in the same cycle.
- Latency: the carry is registered, so ticks appear in the cycle after the overflowing add.
- en=0, sync=0: acc and os_cnt hold; OsTick=0 and BaudTick=0.
- inc_q=0 (written): no ticks, acc frozen in value.
- Maximum inc_q = 2^W-1: OsTick asserts on all cycles except one in every 2^W.
- Long-run rate: exactly inc_q OsTicks per 2^W enabled cycles. Jitter is at most 1 clk on any OsTick edge.
- Oversample=1: os_cnt is a constant 0 and BaudTick equals OsTick.
- Simultaneous sync and inc_wr: both take effect.

Test Plan:
1. Defaults, release rst, en=1 for 2^20 cycles -> exactly 161061 OsTicks, 10066 BaudTicks (floor 161061/16), inc_q=161061 throughout; no two BaudTicks closer than 96 cycles.
2. Write inc_data=0x40000 (2^18), then hold en=1 -> OsTick every 4th cycle, first pulse 4 cycles after the write takes effect; BaudTick every 64 cycles, coincident with an OsTick.
3. With inc=0x40000 running, pulse sync -> next OsTick 4 cycles after sync; first BaudTick after 8 OsTicks (SyncPhase=8), i.e. 32 cycles; then every 64.
4. With inc=0x40000, drop en for 10 cycles mid-period, then raise it -> no ticks while en=0; the period resumes with the remaining count, so a gap of 4+10 cycles between OsTicks.
5. Assert rst asynchronously between edges while BaudTick=1 -> BaudTick, OsTick, acc and os_cnt go to 0 immediately; inc_q returns to 161061.
6. Assert sync, inc_wr(0x80000) and an overflow in the same cycle -> no tick that cycle, inc_q=0x80000, then OsTick every 2 cycles starting 2 cycles later.
